// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter: op bit positions, FSM states, default latency.
// Ops 10-12 (MUL/DIV/REM) are legal only when ALU_ARB_MULDIV_EN is defined.
package alu_arb_pkg;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_AND  = 4;
  localparam int OP_SLL  = 5;
  localparam int OP_SRL  = 6;
  localparam int OP_SRA  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_MUL  = 10;
  localparam int OP_DIV  = 11;
  localparam int OP_REM  = 12;

  localparam int MULDIV_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // One-hot within [12:0], nothing above; multi-cycle ops only when the muldiv unit is enabled.
  function automatic logic op_legal(input logic [15:0] op);
    logic ok;
    ok = (op[15:13] == 3'b000) && $onehot(op[12:0]);
`ifndef ALU_ARB_MULDIV_EN
    ok = ok && (op[OP_REM:OP_MUL] == 3'b000);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant; the pointer flips to the loser side after every accepted grant.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  // A withdrawn request never advances, so the pointer only moves on a real handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight (IDLE -> EXEC -> RESP).
// Define ALU_ARB_MULDIV_EN to enable multi-cycle MUL/DIV/REM; otherwise those ops report rsp_err.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int MULDIV_LAT = MULDIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [15:0] alu_instr,
  input  logic [63:0] alu_out
);

  state_t      state;
  logic        run;
  logic        launched;
  logic        op_id;
  logic [15:0] op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  grant;
  logic        fire;
  logic        fire_id;
  logic        last;
  logic        legal;
  logic        div_zero;
  logic        drive_alu;
  logic [15:0] sel_op;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [63:0] result;

  alu_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (fire),
    .grant   (grant)
  );

  // run keeps req_ready low until the first edge after reset release.
  assign req_ready = (state == ST_IDLE && run) ? grant : 2'b00;
  assign fire      = |(req_valid & req_ready);
  assign fire_id   = req_ready[1];
  assign sel_op    = fire_id ? req_op[31:16] : req_op[15:0];
  assign sel_a     = fire_id ? req_a[63:32]  : req_a[31:0];
  assign sel_b     = fire_id ? req_b[63:32]  : req_b[31:0];

  assign legal     = op_legal(op_q);
  assign div_zero  = legal && (op_q[OP_DIV] || op_q[OP_REM]) && (b_q == 32'h0);
  assign drive_alu = legal && !div_zero;

  always_comb begin
    result = 64'h0;
    if (div_zero) begin
      result = op_q[OP_DIV] ? 64'h0000_0000_FFFF_FFFF : {32'h0, a_q};
    end else if (legal) begin
      result = alu_out;
    end
  end

`ifdef ALU_ARB_MULDIV_EN
  logic [3:0] cnt;
  logic [3:0] lat_init;

  assign lat_init = (drive_alu && (op_q[OP_REM:OP_MUL] != 3'b000)) ? 4'(MULDIV_LAT) : 4'd1;
  assign last     = (cnt == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (state == ST_EXEC) begin
      if (!launched)  cnt <= lat_init;
      else if (!last) cnt <= cnt - 4'd1;
    end else begin
      cnt <= 4'd0;
    end
  end
`else
  assign last = 1'b1;
`endif

  // First EXEC cycle registers the ALU drive; alu_out is captured while alu_instr is still presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      run       <= 1'b0;
      launched  <= 1'b0;
      op_id     <= 1'b0;
      op_q      <= 16'h0;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      alu_instr <= 16'h0;
      alu_in1   <= 32'h0;
      alu_in2   <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 64'h0;
      rsp_err   <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (fire) begin
            state    <= ST_EXEC;
            launched <= 1'b0;
            op_id    <= fire_id;
            op_q     <= sel_op;
            a_q      <= sel_a;
            b_q      <= sel_b;
          end
        end
        ST_EXEC: begin
          if (!launched) begin
            launched  <= 1'b1;
            alu_in1   <= a_q;
            alu_in2   <= b_q;
            alu_instr <= drive_alu ? op_q : 16'h0;
          end else if (last) begin
            state     <= ST_RESP;
            launched  <= 1'b0;
            alu_instr <= 16'h0;
            alu_in1   <= 32'h0;
            alu_in2   <= 32'h0;
            rsp_valid <= 1'b1;
            rsp_id    <= op_id;
            rsp_err   <= ~legal;
            rsp_data  <= result;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 64'h0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter; models the shared ALU and round-robin at op-index level.
// Honours ALU_ARB_MULDIV_EN the same way as the design.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int LAT = 4;
`ifdef ALU_ARB_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_op = 32'h0;
  logic [63:0] req_a = 64'h0;
  logic [63:0] req_b = 64'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [15:0] alu_instr;
  logic [63:0] alu_out;

  typedef struct {
    logic        id;
    logic [15:0] op;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          icyc;
    int          acc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         busy = 1'b0;
  bit         ptr = 1'b0;
  logic [1:0] last_hs = 2'b00;

  alu_arbiter #(.MULDIV_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_instr (alu_instr),
    .alu_out   (alu_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_alu(input int k, input logic [31:0] a, input logic [31:0] b);
    case (k)
      0:  return {32'h0, a + b};
      1:  return {32'h0, a - b};
      2:  return {32'h0, a ^ b};
      3:  return {32'h0, a | b};
      4:  return {32'h0, a & b};
      5:  return {32'h0, a << b[4:0]};
      6:  return {32'h0, a >> b[4:0]};
      7:  return {32'h0, 32'($signed(a) >>> b[4:0])};
      8:  return {63'h0, $signed(a) < $signed(b)};
      9:  return {63'h0, a < b};
      10: return {32'h0, a} * {32'h0, b};
      11: return (b == 32'h0) ? 64'h0BAD_0BAD_0BAD_0BAD : {32'h0, a / b};
      12: return (b == 32'h0) ? 64'h0BAD_0BAD_0BAD_0BAD : {32'h0, a % b};
      default: return 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  endfunction

  // External ALU: garbage whenever no single op is presented.
  always_comb begin
    alu_out = 64'hDEAD_BEEF_0BAD_F00D;
    if ($onehot(alu_instr)) begin
      for (int k = 0; k < 16; k++) begin
        if (alu_instr[k]) alu_out = ref_alu(k, alu_in1, alu_in2);
      end
    end
  end

  function automatic exp_t model(input logic id, input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   k;
    bit   legal;
    e.id = id; e.op = op; e.err = 1'b0; e.data = 64'h0; e.lat = 1; e.icyc = 0; e.acc = 0;
    legal = (op[15:13] == 3'b000) && ($countones(op[12:0]) == 1);
    k = 0;
    for (int j = 0; j < 13; j++) if (op[j]) k = j;
    if (k >= 10 && !MD) legal = 1'b0;
    if (!legal) begin
      e.err = 1'b1;
      return e;
    end
    if ((k == 11 || k == 12) && b == 32'h0) begin
      e.data = (k == 11) ? 64'h0000_0000_FFFF_FFFF : {32'h0, a};
      return e;
    end
    e.data = ref_alu(k, a, b);
    e.lat  = (k >= 10) ? LAT : 1;
    e.icyc = e.lat;
    return e;
  endfunction

  function automatic logic [1:0] rr(input logic [1:0] v, input bit p);
    if (v == 2'b00) return 2'b00;
    if (v[p]) return p ? 2'b10 : 2'b01;
    return p ? 2'b01 : 2'b10;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[16*i +: 16] = op;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
  endtask

  task automatic rand_req(input int i);
    logic [15:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int          k;
    op = 16'h0;
    if ($urandom_range(9) < 8) begin
      k = $urandom_range(12);
      op[k] = 1'b1;
    end else begin
      op = 16'($urandom);
    end
    a = $urandom;
    b = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
    set_req(i, op, a, b);
  endtask

  // One cycle: check grant against the model, log handshakes into the scoreboard, return at posedge+1.
  task automatic tick();
    logic [1:0] hs;
    logic       id;
    exp_t       e;
    @(negedge clk);
    last_hs = 2'b00;
    if (rst_n) begin
      if (req_valid != 2'b00) check("grant", req_ready, busy ? 2'b00 : rr(req_valid, ptr));
      hs = req_valid & req_ready;
      if (rsp_valid && rsp_ready) busy = 1'b0;
      if (hs != 2'b00) begin
        id = hs[1];
        e = model(id, id ? req_op[31:16] : req_op[15:0], id ? req_a[63:32] : req_a[31:0],
                  id ? req_b[63:32] : req_b[31:0]);
        e.acc = cyc;
        sb.push_back(e);
        busy = 1'b1;
        ptr = !id;
        last_hs = hs;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int budget);
    int n;
    n = 0;
    while ((req_valid != 2'b00 || busy) && n < budget) begin
      tick();
      req_valid &= ~last_hs;
      n++;
    end
    check("settle_timeout", n >= budget, 1'b0);
  endtask

  task automatic one(input int i, input logic [15:0] op, input logic [31:0] a, input logic [31:0] b);
    set_req(i, op, a, b);
    req_valid[i] = 1'b1;
    settle(60);
  endtask

  // Monitor: pops on each new response, checks payload, latency, ALU drive and hold stability.
  initial begin : monitor
    bit          pend;
    int          icnt;
    bit          ibad;
    logic [65:0] hold;
    exp_t        e;
    pend = 1'b0; icnt = 0; ibad = 1'b0; hold = 66'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; icnt = 0; ibad = 1'b0;
      end else begin
        if (alu_instr != 16'h0) begin
          icnt++;
          if (sb.size() == 0 || alu_instr != sb[0].op) ibad = 1'b1;
        end
        if (rsp_valid && !pend) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_rsp: got rsp_valid=1 with id=%0d data=%0h expected no response", rsp_id, rsp_data);
          end else begin
            e = sb.pop_front();
            $display("rsp id=%0d op=%04h data=%016h err=%0d lat=%0d", rsp_id, e.op, rsp_data, rsp_err, cyc - e.acc - 1);
            check("rsp_id", rsp_id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", rsp_err, e.err);
            check("latency", cyc - e.acc, 2 + e.lat);
            check("alu_instr_cycles", icnt, e.icyc);
            check("alu_instr_value", ibad, 1'b0);
          end
          icnt = 0; ibad = 1'b0;
          hold = {rsp_id, rsp_err, rsp_data};
        end else if (rsp_valid && pend) begin
          check("rsp_stable", {rsp_id, rsp_err, rsp_data}, hold);
          check("ready_in_resp", req_ready, 2'b00);
        end
        pend = rsp_valid && !rsp_ready;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // Both requesters valid during reset: req_ready must still be held low.
    set_req(0, 16'h0002, 32'd100, 32'd58);
    set_req(1, 16'h0004, 32'hF0F0_1234, 32'h0FF0_FFFF);
    req_valid = 2'b11;
    #3;
    check("rst_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, alu_instr}, 0);
    check("rst_data", {rsp_data, alu_in1, alu_in2}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    settle(60);
    set_req(0, 16'h0001, 32'd1, 32'd2);
    set_req(1, 16'h0008, 32'd3, 32'd4);
    req_valid = 2'b11;
    settle(60);

    one(0, 16'h0001, 32'hFFFF_FFFB, 32'd4);
    one(1, 16'h0400, 32'd123456, 32'd789);
    one(1, 16'h0800, 32'd10, 32'd0);
    one(0, 16'h1000, 32'd10, 32'd0);

    // Illegal op held in RESP while the other requester waits.
    rsp_ready = 1'b0;
    set_req(0, 16'h0003, 32'd7, 32'd9);
    req_valid = 2'b01;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      req_valid &= ~last_hs;
      n++;
    end
    check("rsp_wait_timeout", n >= 20, 1'b0);
    set_req(1, 16'h0001, 32'd5, 32'd6);
    req_valid = 2'b10;
    repeat (5) tick();
    rsp_ready = 1'b1;
    settle(60);

    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (last_hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(2) == 0) begin
          rand_req(i);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && !last_hs[i] && $urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
    end
    rsp_ready = 1'b1;
    settle(200);

    // Reset in the middle of a MUL: everything clears at once and nothing is answered.
    one(0, 16'h0001, 32'd1, 32'd1);
    set_req(1, 16'h0400, 32'd7, 32'd9);
    req_valid = 2'b10;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_hs == 2'b00 && n < 20);
    req_valid = 2'b00;
    set_req(0, 16'h0400, 32'd11, 32'd13);
    req_valid = 2'b01;
    n = 0;
    do begin
      tick();
      n++;
    end while (last_hs == 2'b00 && n < 20);
    req_valid = 2'b00;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", {req_ready, rsp_valid, rsp_id, rsp_err, alu_instr}, 0);
    check("arst_data", {rsp_data, alu_in1, alu_in2}, 0);
    sb.delete();
    busy = 1'b0;
    ptr = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (6) begin
      tick();
      check("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    set_req(0, 16'h0010, 32'hFF00_FF00, 32'h0F0F_0F0F);
    set_req(1, 16'h0020, 32'd1, 32'd3);
    req_valid = 2'b11;
    tick();
    check("post_rst_grant", last_hs, 2'b01);
    req_valid &= ~last_hs;
    settle(60);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
